// File: rtl/fixed_point_calc_core.sv
// Signed fixed-point calculator engine: builds integer operands from key events and evaluates
// + - * / left-to-right in Q(DATA_W-FRAC_W).FRAC_W, with saturation, divide-by-zero and busy control.
module fixed_point_calc_core #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 4,
  parameter int MAX_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_vld,
  input  logic [4:0]        key_code,
  output logic              key_rdy,
  output logic              busy,
  output logic [2:0]        op_pend,
  output logic [DATA_W-1:0] display,
  output logic [DATA_W-1:0] result,
  output logic              result_vld,
  output logic              ovf,
  output logic              err
);

  localparam int INT_W  = DATA_W - FRAC_W;
  localparam int DIVN_W = DATA_W + FRAC_W;
  localparam int WIDE   = 2 * DATA_W;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int DC_W   = $clog2(DIVN_W);

  localparam logic [INT_W+3:0]        IMAX_EXT = {5'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SMAX_W   = $signed({{(WIDE-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [WIDE-1:0] SMIN_W   = ~SMAX_W;

  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OP, S_OPB, S_EXEC, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t                    state_q, state_d;
  op_t                       op_pend_q, op_pend_d, next_op_q, next_op_d;
  logic                      next_eq_q, next_eq_d;
  logic signed [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]         result_q, result_d;
  logic [INT_W-1:0]          entry_q, entry_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      result_vld_q, result_vld_d;
  logic                      ovf_q, ovf_d, err_q, err_d;
  logic [DIVN_W-1:0]         div_q_q, div_q_d;
  logic [DATA_W-1:0]         div_rem_q, div_rem_d, div_den_q, div_den_d;
  logic [DC_W-1:0]           div_cnt_q, div_cnt_d;
  logic                      div_neg_q, div_neg_d, div_run_q, div_run_d;

  // Clamp a wide signed value into DATA_W; MSB of the return flags that clamping happened.
  function automatic logic [DATA_W:0] saturate(input logic signed [WIDE-1:0] v);
    if (v > SMAX_W) return {1'b1, SMAX_W[DATA_W-1:0]};
    if (v < SMIN_W) return {1'b1, SMIN_W[DATA_W-1:0]};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic                     key_digit, key_op, key_eq, key_clr, append_ok, div_ge, exec_done;
  op_t                      key_opv;
  logic [INT_W+3:0]         entry_ext;
  logic [DATA_W-1:0]        commit_val, a_mag;
  logic signed [WIDE-1:0]   a_w, b_w, prod_w, q_w, exec_val;
  logic [DATA_W:0]          div_shift, sat_res;
  logic [DIVN_W-1:0]        div_q_it;

  assign key_digit  = key_vld && (key_code <= 5'd9);
  assign key_op     = key_vld && (key_code >= 5'd10) && (key_code <= 5'd13);
  assign key_eq     = key_vld && (key_code == 5'd14);
  assign key_clr    = key_vld && (key_code == 5'd15);
  assign key_opv    = op_t'(key_code[2:0] - 3'd1);

  assign entry_ext  = (INT_W+4)'(entry_q) * (INT_W+4)'(10) + (INT_W+4)'(key_code[3:0]);
  assign append_ok  = (cnt_q < CNT_W'(MAX_DIGITS)) && (entry_ext <= IMAX_EXT);
  assign commit_val = {entry_q, {FRAC_W{1'b0}}};

  assign a_w        = WIDE'(acc_q);
  assign b_w        = $signed(WIDE'(commit_val));
  assign prod_w     = a_w * b_w;
  assign a_mag      = acc_q[DATA_W-1] ? DATA_W'(-acc_q) : DATA_W'(acc_q);

  // One restoring step: bring down the next dividend bit and subtract the divisor if it fits.
  assign div_shift  = {div_rem_q, div_q_q[DIVN_W-1]};
  assign div_ge     = div_shift >= {1'b0, div_den_q};
  assign div_q_it   = {div_q_q[DIVN_W-2:0], div_ge};
  assign q_w        = $signed(WIDE'(div_q_it));

  // NOTE: every variable driven here gets a default first, otherwise synthesis infers latches.
  always_comb begin
    state_d      = state_q;
    op_pend_d    = op_pend_q;
    next_op_d    = next_op_q;
    next_eq_d    = next_eq_q;
    acc_d        = acc_q;
    result_d     = result_q;
    entry_d      = entry_q;
    cnt_d        = cnt_q;
    result_vld_d = 1'b0;
    ovf_d        = ovf_q;
    err_d        = err_q;
    div_q_d      = div_q_q;
    div_rem_d    = div_rem_q;
    div_den_d    = div_den_q;
    div_cnt_d    = div_cnt_q;
    div_neg_d    = div_neg_q;
    div_run_d    = div_run_q;
    exec_done    = 1'b0;
    exec_val     = '0;

    case (state_q)
      S_IDLE: begin
        if (key_digit) begin
          entry_d = INT_W'(key_code[3:0]); cnt_d = CNT_W'(1); state_d = S_OPA;
        end else if (key_op) begin
          acc_d = '0; op_pend_d = key_opv; state_d = S_OP;
        end
      end
      S_OPA, S_OPB: begin
        if (key_digit) begin
          if (append_ok) begin
            entry_d = entry_ext[INT_W-1:0]; cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (state_q == S_OPA) begin
          if (key_op) begin
            acc_d = $signed(commit_val); op_pend_d = key_opv; state_d = S_OP;
          end else if (key_eq) begin
            result_d = commit_val; result_vld_d = 1'b1; op_pend_d = OP_NONE; state_d = S_DONE;
          end
        end else if (key_op || key_eq) begin
          next_op_d = key_opv; next_eq_d = key_eq; state_d = S_EXEC;
        end
      end
      S_OP: begin
        if (key_digit) begin
          entry_d = INT_W'(key_code[3:0]); cnt_d = CNT_W'(1); state_d = S_OPB;
        end else if (key_op) begin
          op_pend_d = key_opv;
        end else if (key_eq) begin
          result_d = acc_q; result_vld_d = 1'b1; op_pend_d = OP_NONE; state_d = S_DONE;
        end
      end
      S_EXEC: begin
        case (op_pend_q)
          OP_ADD:  begin exec_val = a_w + b_w; exec_done = 1'b1; end
          OP_SUB:  begin exec_val = a_w - b_w; exec_done = 1'b1; end
          OP_MUL:  begin exec_val = prod_w >>> FRAC_W; exec_done = 1'b1; end
          OP_DIV: begin
            if (!div_run_q) begin
              if (entry_q == '0) begin
                err_d = 1'b1; state_d = S_ERR;
              end else begin
                div_q_d   = {a_mag, {FRAC_W{1'b0}}};
                div_rem_d = '0;
                div_den_d = commit_val;
                div_neg_d = acc_q[DATA_W-1];
                div_cnt_d = '0;
                div_run_d = 1'b1;
              end
            end else begin
              div_q_d   = div_q_it;
              div_rem_d = div_ge ? DATA_W'(div_shift - {1'b0, div_den_q}) : div_shift[DATA_W-1:0];
              div_cnt_d = div_cnt_q + DC_W'(1);
              if (div_cnt_q == DC_W'(DIVN_W-1)) begin
                exec_val  = div_neg_q ? -q_w : q_w;
                exec_done = 1'b1;
              end
            end
          end
          default: begin exec_val = a_w; exec_done = 1'b1; end
        endcase
      end
      S_DONE: begin
        if (key_digit) begin
          acc_d = '0; entry_d = INT_W'(key_code[3:0]); cnt_d = CNT_W'(1); state_d = S_OPA;
        end else if (key_op) begin
          acc_d = $signed(result_q); op_pend_d = key_opv; state_d = S_OP;
        end
      end
      default: ;
    endcase

    sat_res = saturate(exec_val);
    if (exec_done) begin
      acc_d     = $signed(sat_res[DATA_W-1:0]);
      ovf_d     = ovf_q | sat_res[DATA_W];
      div_run_d = 1'b0;
      if (next_eq_q) begin
        result_d = sat_res[DATA_W-1:0]; result_vld_d = 1'b1; op_pend_d = OP_NONE; state_d = S_DONE;
      end else begin
        op_pend_d = next_op_q; state_d = S_OP;
      end
    end

    // CLEAR overrides everything, including a divide about to complete.
    if (key_clr) begin
      state_d = S_IDLE; op_pend_d = OP_NONE; next_op_d = OP_NONE; next_eq_d = 1'b0;
      acc_d = '0; result_d = '0; entry_d = '0; cnt_d = '0; result_vld_d = 1'b0;
      ovf_d = 1'b0; err_d = 1'b0; div_q_d = '0; div_rem_d = '0; div_den_d = '0;
      div_cnt_d = '0; div_neg_d = 1'b0; div_run_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from the same old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; op_pend_q <= OP_NONE; next_op_q <= OP_NONE; next_eq_q <= 1'b0;
      acc_q <= '0; result_q <= '0; entry_q <= '0; cnt_q <= '0; result_vld_q <= 1'b0;
      ovf_q <= 1'b0; err_q <= 1'b0; div_q_q <= '0; div_rem_q <= '0; div_den_q <= '0;
      div_cnt_q <= '0; div_neg_q <= 1'b0; div_run_q <= 1'b0;
    end else begin
      state_q <= state_d; op_pend_q <= op_pend_d; next_op_q <= next_op_d; next_eq_q <= next_eq_d;
      acc_q <= acc_d; result_q <= result_d; entry_q <= entry_d; cnt_q <= cnt_d;
      result_vld_q <= result_vld_d; ovf_q <= ovf_d; err_q <= err_d; div_q_q <= div_q_d;
      div_rem_q <= div_rem_d; div_den_q <= div_den_d; div_cnt_q <= div_cnt_d;
      div_neg_q <= div_neg_d; div_run_q <= div_run_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OPA, S_OPB:  display = commit_val;
      S_OP, S_EXEC:  display = acc_q;
      S_DONE:        display = result_q;
      default:       display = '0;
    endcase
  end

  assign busy       = (state_q == S_EXEC);
  assign key_rdy    = ~busy;
  assign op_pend    = op_pend_q;
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign ovf        = ovf_q;
  assign err        = err_q;

endmodule
